// File: rtl/j4_slotctl.sv
// j4_slotctl: N-slot task-vector registers, kill/restart pulse generator and optional per-slot watchdog.
// Define SLOTCTL_WDOG_EN to build the watchdog, its prescaler and IO functions 2 (WDOG) and 3 (KICK).
module j4_slotctl #(
    parameter int unsigned SLOTS   = 4,
    parameter int unsigned WDOG_W  = 16,
    parameter int unsigned PRESC_W = 8,
    parameter int unsigned SEL_BIT = 11,
    localparam int unsigned SW     = $clog2(SLOTS)
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             io_wr_,
    input  logic             io_rd_,
    input  logic [15:0]      io_addr_,
    input  logic [15:0]      dout_,
    input  logic [SW-1:0]    io_thread_,
    output logic [15:0]      rd_data,
    output logic [SLOTS-1:0] kill_slot_rq
);

    logic             sel;
    logic [1:0]       fn;
    logic [SW-1:0]    slot;
    logic             task_we;
    logic             kill_we;
    logic [15:0]      task_q [SLOTS];
    logic [SLOTS-1:0] kill_wr_c;
    logic [SLOTS-1:0] expire_c;

    assign sel     = io_addr_[SEL_BIT];
    assign fn      = io_addr_[3:2];
    assign slot    = io_addr_[4+SW-1:4];
    assign task_we = sel && io_wr_ && (fn == 2'd0);
    assign kill_we = sel && io_wr_ && (fn == 2'd1);

    // Slot 0 (supervisor) may restart any other slot; other slots may only restart themselves.
    always_comb begin
        kill_wr_c = '0;
        if (io_thread_ == '0) begin
            kill_wr_c = dout_[SLOTS-1:0] & ~SLOTS'(1);
        end else begin
            kill_wr_c = SLOTS'(1) << io_thread_;
        end
    end

    // task_q[0] is never written and stays 0.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int unsigned k = 0; k < SLOTS; k++) begin
                task_q[k] <= '0;
            end
        end else if (task_we && (slot != '0)) begin
            task_q[slot] <= dout_;
        end
    end

`ifdef SLOTCTL_WDOG_EN
    logic [PRESC_W-1:0] presc_q;
    logic               tick;
    logic               wdog_we;
    logic               kick_we;
    logic               exp_clr;
    logic [WDOG_W-1:0]  reload_q [SLOTS];
    logic [WDOG_W-1:0]  cnt_q    [SLOTS];
    logic [SLOTS-1:0]   expired_q;

    assign tick    = &presc_q;
    assign wdog_we = sel && io_wr_ && (fn == 2'd2);
    assign kick_we = sel && io_wr_ && (fn == 2'd3);
    assign exp_clr = sel && io_rd_ && (fn == 2'd3);

    // A WDOG or KICK write to a slot in the tick cycle suppresses that slot's expiry.
    always_comb begin
        expire_c = '0;
        for (int unsigned k = 1; k < SLOTS; k++) begin
            if (tick && (cnt_q[k] == WDOG_W'(1))
                && !(wdog_we && (slot == SW'(k)))
                && !(kick_we && (io_thread_ == SW'(k)))) begin
                expire_c[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            presc_q   <= '0;
            expired_q <= '0;
            for (int unsigned k = 0; k < SLOTS; k++) begin
                reload_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
            for (int unsigned k = 1; k < SLOTS; k++) begin
                if (wdog_we && (slot == SW'(k))) begin
                    reload_q[k] <= dout_[WDOG_W-1:0];
                    cnt_q[k]    <= dout_[WDOG_W-1:0];
                end else if (kick_we && (io_thread_ == SW'(k))) begin
                    cnt_q[k] <= reload_q[k];
                end else if (expire_c[k]) begin
                    cnt_q[k] <= reload_q[k];
                end else if (tick && (cnt_q[k] != '0)) begin
                    cnt_q[k] <= cnt_q[k] - WDOG_W'(1);
                end
            end
            // A new expiry wins over the clearing read in the same cycle.
            expired_q <= exp_clr ? expire_c : (expired_q | expire_c);
        end
    end
`else
    assign expire_c = '0;
`endif

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (fn)
                2'd0:    rd_data = task_q[io_thread_];
                2'd1:    rd_data = 16'(io_thread_);
`ifdef SLOTCTL_WDOG_EN
                2'd2:    rd_data = 16'(cnt_q[slot]);
                2'd3:    rd_data = 16'(expired_q);
`endif
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            kill_slot_rq <= '0;
        end else begin
            kill_slot_rq <= (kill_we ? kill_wr_c : '0) | expire_c;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{io_addr_, dout_, io_rd_};

endmodule

// File: tb/tb_j4_slotctl.sv
// tb_j4_slotctl: directed and random stimulus against a cycle-level behavioural model of j4_slotctl.
// Exercises the watchdog when SLOTCTL_WDOG_EN is defined, the reduced block (SLOTS=8) otherwise.
module tb_j4_slotctl;

`ifdef SLOTCTL_WDOG_EN
    localparam int SLOTS = 4;
    localparam int PRESC = 2;
    localparam bit EN    = 1'b1;
`else
    localparam int SLOTS = 8;
    localparam int PRESC = 8;
    localparam bit EN    = 1'b0;
`endif
    localparam int SW   = $clog2(SLOTS);
    localparam int SEL  = 11;
    localparam int PMAX = (1 << PRESC) - 1;

    logic             clk;
    logic             resetq;
    logic             io_wr_;
    logic             io_rd_;
    logic [15:0]      io_addr_;
    logic [15:0]      dout_;
    logic [SW-1:0]    io_thread_;
    logic [15:0]      rd_data;
    logic [SLOTS-1:0] kill_slot_rq;

    j4_slotctl #(.SLOTS(SLOTS), .WDOG_W(16), .PRESC_W(PRESC), .SEL_BIT(SEL)) dut (
        .clk(clk), .resetq(resetq), .io_wr_(io_wr_), .io_rd_(io_rd_),
        .io_addr_(io_addr_), .dout_(dout_), .io_thread_(io_thread_),
        .rd_data(rd_data), .kill_slot_rq(kill_slot_rq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_task [SLOTS];
    int m_reload [SLOTS];
    int m_cnt [SLOTS];
    int m_exp, m_kill, m_phase;
    int last_kill, last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] A(input int f, input int s);
        return 16'((1 << SEL) | (s << 4) | (f << 2));
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < SLOTS; k++) begin
            m_task[k] = 0; m_reload[k] = 0; m_cnt[k] = 0;
        end
        m_exp = 0; m_kill = 0; m_phase = 0;
    endfunction

    function automatic logic [15:0] model_rd(input logic [15:0] a, input int thr);
        int f, s;
        if (!a[SEL]) return 16'h0;
        f = int'(a[3:2]);
        s = int'(a >> 4) % SLOTS;
        case (f)
            0: return 16'(m_task[thr]);
            1: return 16'(thr);
            2: return EN ? 16'(m_cnt[s]) : 16'h0;
            default: return EN ? 16'(m_exp) : 16'h0;
        endcase
    endfunction

    // Applies the effect of one clock edge given the inputs held during that cycle.
    function automatic void model_update(input logic wr, input logic rd, input logic [15:0] a,
                                         input logic [15:0] d, input int thr);
        bit sel;
        int f, s, knew, enew;
        bit tick;
        sel  = a[SEL];
        f    = int'(a[3:2]);
        s    = int'(a >> 4) % SLOTS;
        knew = 0;
        enew = 0;
        if (sel && wr && f == 0 && s != 0) m_task[s] = int'(d);
        if (sel && wr && f == 1)
            knew = (thr == 0) ? (int'(d) & ((1 << SLOTS) - 1) & ~1) : (1 << thr);
        if (EN) begin
            tick    = (m_phase == PMAX);
            m_phase = (m_phase + 1) % (PMAX + 1);
            for (int k = 1; k < SLOTS; k++) begin
                if (sel && wr && f == 2 && s == k) begin
                    m_reload[k] = int'(d); m_cnt[k] = int'(d);
                end else if (sel && wr && f == 3 && thr == k) begin
                    m_cnt[k] = m_reload[k];
                end else if (tick && m_cnt[k] == 1) begin
                    m_cnt[k] = m_reload[k]; enew |= (1 << k);
                end else if (tick && m_cnt[k] > 1) begin
                    m_cnt[k] = m_cnt[k] - 1;
                end
            end
            m_exp = (sel && rd && f == 3) ? enew : (m_exp | enew);
        end
        m_kill = knew | enew;
    endfunction

    // One clock cycle: drive at negedge, check read data, then check the registered kill output.
    task automatic step(input logic wr, input logic rd, input logic [15:0] a,
                        input logic [15:0] d, input int thr);
        io_wr_ = wr; io_rd_ = rd; io_addr_ = a; dout_ = d; io_thread_ = SW'(thr);
        #1;
        last_rd = int'(rd_data);
        chk("rd_data", rd_data, model_rd(a, thr));
        @(posedge clk);
        model_update(wr, rd, a, d, thr);
        #1;
        last_kill = int'(kill_slot_rq);
        chk("kill", kill_slot_rq, m_kill);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 16'h0, 0);
    endtask

    initial begin
        int n, g, f, s, thr, op;
        logic [15:0] a, d;
        resetq = 1'b0; io_wr_ = 1'b0; io_rd_ = 1'b0; io_addr_ = A(0, 0); dout_ = 16'h0;
        io_thread_ = SW'(1);
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_kill", kill_slot_rq, 0);
        chk("rst_rd", rd_data, 0);
        @(negedge clk);
        resetq = 1'b1;

        // Task vectors
        step(1, 0, A(0, 2), 16'h0123, 0);
        step(0, 1, A(0, 0), 16'h0, 2);      chk("task_s2", last_rd, 16'h0123);
        step(0, 1, A(0, 0), 16'h0, 0);      chk("task_s0", last_rd, 0);
        step(1, 0, A(0, 0), 16'hBEEF, 0);
        step(0, 1, A(0, 0), 16'h0, 0);      chk("task_s0_wr", last_rd, 0);
        step(0, 1, 16'h0, 16'h0, 2);        chk("unsel_rd", last_rd, 0);

        // Kill pulses
        step(1, 0, A(1, 0), 16'h000F, 0);   chk("kill_s0", last_kill, 32'hE);
        idle();                             chk("kill_1cyc", last_kill, 0);
        step(1, 0, A(1, 0), 16'h1234, 3);   chk("kill_s3", last_kill, 32'h8);
        step(0, 1, A(1, 0), 16'h0, 3);      chk("thread_rd", last_rd, 3);

`ifdef SLOTCTL_WDOG_EN
        // Arm slot 1 with 3; pulse after 3 ticks, then periodic every 3 ticks
        step(1, 0, A(2, 1), 16'd3, 0);
        g = 0;
        while (last_kill == 0 && g < 16) begin idle(); g++; end
        chk("wdog_pulse", last_kill, 32'h2);
        step(0, 1, A(3, 0), 16'h0, 0);      chk("exp_rd1", last_rd, 32'h2);
        step(0, 1, A(3, 0), 16'h0, 0);      chk("exp_rd2", last_rd, 0);
        n = 2;
        while (last_kill == 0 && n < 20) begin idle(); n++; end
        chk("wdog_period", n, 12);
        step(1, 0, A(2, 1), 16'd0, 0);

        // Periodic kicks keep slot 1 alive
        step(1, 0, A(2, 1), 16'd3, 0);
        n = 0;
        repeat (10) begin
            repeat (7) begin idle(); if (last_kill != 0) n++; end
            step(1, 0, A(3, 0), 16'hFFFF, 1); if (last_kill != 0) n++;
        end
        chk("kick_keep", n, 0);

        // Kick in the same cycle as the cnt=1 tick
        g = 0;
        while (!(m_cnt[1] == 1 && m_phase == PMAX) && g < 40) begin idle(); g++; end
        chk("kick_race_setup", m_cnt[1], 1);
        step(1, 0, A(3, 0), 16'h0, 1);      chk("kick_race", last_kill, 0);
        step(1, 0, A(2, 1), 16'd0, 0);

        // Expiry of slot 2 merged with a supervisor KILL write
        step(1, 0, A(2, 2), 16'd1, 0);
        g = 0;
        while (m_phase != PMAX && g < 8) begin idle(); g++; end
        step(1, 0, A(1, 0), 16'h0008, 0);   chk("kill_merge", last_kill, 32'hC);
        step(1, 0, A(2, 2), 16'd0, 0);

        // Reset in the middle of a countdown
        step(1, 0, A(2, 1), 16'd3, 0);
        repeat (5) idle();
        io_wr_ = 1'b0; io_rd_ = 1'b1; io_addr_ = A(2, 1); io_thread_ = SW'(0);
        #2 resetq = 1'b0;
        #1;
        chk("midrst_kill", kill_slot_rq, 0);
        chk("midrst_cnt", rd_data, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetq = 1'b1;
        n = 0;
        repeat (40) begin idle(); if (last_kill != 0) n++; end
        chk("midrst_nopulse", n, 0);
`else
        step(1, 0, A(1, 0), 16'h00FF, 0);   chk("kill_ff", last_kill, 32'hFE);
        step(1, 0, A(2, 1), 16'd5, 0);
        step(1, 0, A(3, 0), 16'h0, 1);
        step(0, 1, A(2, 1), 16'h0, 0);      chk("f2_rd", last_rd, 0);
        step(0, 1, A(3, 0), 16'h0, 0);      chk("f3_rd", last_rd, 0);
        n = 0;
        repeat (300) begin idle(); if (last_kill != 0) n++; end
        chk("no_pulse", n, 0);
`endif

        // Random traffic against the model
        repeat (400) begin
            op  = int'($urandom_range(0, 3));
            f   = int'($urandom_range(0, 3));
            s   = int'($urandom_range(0, SLOTS - 1));
            thr = int'($urandom_range(0, SLOTS - 1));
            a   = A(f, s);
            if ($urandom_range(0, 7) == 0) a = 16'($urandom) & ~16'(1 << SEL);
            d   = (f == 2) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            case (op)
                0: idle();
                1: step(1, 0, a, d, thr);
                default: step(0, 1, a, d, thr);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/j4_slotctl.md
# j4_slotctl

Parametrised per-slot task and supervision controller for the multi-slot j4 core: holds the task-vector register of every hardware slot, generates the `kill_slot_rq` restart pulses, and optionally runs a per-slot watchdog that restarts a hung slot. It sits on the delayed IO bus of the top level. Its `rd_data` is ORed into `io_din`, and `kill_slot_rq` drives the core directly. It replaces the fixed 4-slot task and kill decode with an N-slot block.

## Interface
Parameters:
- `SLOTS`, 4: number of hardware slots; a power of two, 2..16. `SW = log2(SLOTS)` is derived.
- `WDOG_W`, 16: width of each watchdog counter.
- `PRESC_W`, 8: watchdog tick every 2^PRESC_W clocks.
- `SEL_BIT`, 11: the `io_addr_` bit that selects this block.

Ports:
- `clk` in 1: the single clock.
- `resetq` in 1: asynchronous, active-low reset.
- `io_wr_` in 1: registered IO write strobe.
- `io_rd_` in 1: registered IO read strobe.
- `io_addr_` in 16: registered IO address; zero when no access.
- `dout_` in 16: registered write data.
- `io_thread_` in SW: slot issuing the current access.
- `rd_data` out 16: read data, combinational from the registered inputs.
- `kill_slot_rq` out SLOTS: registered one-cycle restart pulses, one bit per slot.

## Operation
- The block is selected when `io_addr_[SEL_BIT]` = 1.
  - Function `f = io_addr_[3:2]`.
  - Target slot `s = io_addr_[4+SW-1:4]`.
  - When the block is not selected, `rd_data` = 0 and writes are ignored.
- f=0, TASK:
  - Write: `task[s] <= dout_`. A write with s=0 is ignored; `task[0]` is hard-wired to 0.
  - Read: returns `task[io_thread_]`, not `task[s]`.
- f=1, KILL:
  - Write from slot 0: `kill_slot_rq <= dout_[SLOTS-1:0]` with bit 0 forced to 0.
  - Write from slot k≠0: `kill_slot_rq <= 1<<k` (self-restart only).
  - Read: returns the zero-extended `io_thread_`.
- f=2, WDOG:
  - Write with s≠0: `reload[s] <= dout_[WDOG_W-1:0]` and `cnt[s] <= dout_[WDOG_W-1:0]`. Writing 0 disarms the watchdog. A write with s=0 is ignored.
  - Read: returns `cnt[s]`.
- f=3, KICK:
  - Write (any data): `cnt[io_thread_] <= reload[io_thread_]`. Ignored from slot 0.
  - Read: returns the sticky `expired[SLOTS-1:0]`. The read clears those bits at the next edge.
- Watchdog tick: the prescaler wraps from all-ones to 0. On a tick:
  - Each `cnt[k]` with k≠0 and value > 1 decrements by 1.
  - Each `cnt[k]` == 1 reloads from `reload[k]`, sets `expired[k]`, and ORs 1<<k into the next `kill_slot_rq`.
  - A `cnt[k]` == 0 stays at 0 (disarmed).
- Simultaneous events:
  - KILL write plus watchdog expiry in the same cycle: the pulse is the OR of both.
  - KICK or WDOG write to slot k plus a tick in the same cycle: the write wins; no expiry and no kill for k.
  - An expiry and a clearing read of `expired` in the same cycle: the set wins.
- `kill_slot_rq` is zero in every cycle in which no kill source is active.

## Timing
- Reset (asynchronous, `resetq` low) clears all of the following, and they hold at 0 until `resetq` rises:
  - every `task`, `reload` and `cnt`;
  - `expired`;
  - the prescaler;
  - `kill_slot_rq`.
- Reset in the middle of a countdown discards the countdown; the watchdog stays disarmed until a WDOG write.
- `rd_data` is valid in the same cycle as the registered address, with zero latency.
- A register write is visible one clock after the `io_wr_` cycle.
- Kill pulse timing:
  - `kill_slot_rq` rises on the edge after the KILL write or expiry tick.
  - It is high for exactly 1 cycle.
- Expiry latency after arming with value R: the kill pulse occurs R ticks later. The first tick can be up to 2^PRESC_W cycles away, depending on prescaler phase.

## Configuration
- `SLOTCTL_WDOG_EN` defined: the watchdog, prescaler, `reload`/`cnt`/`expired` registers and functions f=2/3 are present.
- `SLOTCTL_WDOG_EN` undefined:
  - None of that logic is built.
  - f=2/3 reads return 0 and writes are ignored.
  - `kill_slot_rq` comes from KILL writes only.

## Test plan
- Reset, then a TASK write of 0x0123 to s=2 from slot 0; slot 2 reads f=0 → 0x0123; slot 0 reads f=0 → 0x0000; a TASK write to s=0 leaves slot 0's read at 0.
- Slot 0 KILL write 0x000F → `kill_slot_rq` = 0xE for exactly 1 cycle. Slot 3 KILL write of any data → 0x8.
- PRESC_W=2, WDOG write 3 to s=1 → `kill_slot_rq` = 0x2 after 3 ticks, `expired` reads 0x2, a second read returns 0x0, and the next pulse follows 3 ticks later.
- Slot 1 KICKs every 2 ticks with reload 3 → no kill pulse over 20 ticks. A KICK landing in the same cycle as the cnt=1 tick → no pulse.
- Expiry of slot 2 in the same cycle as a slot-0 KILL write of 0x0008 → `kill_slot_rq` = 0xC. Reset asserted mid-countdown → outputs 0 immediately and no pulse afterwards.
- SLOTS=8 with `SLOTCTL_WDOG_EN` undefined → f=2/3 reads 0, KILL from slot 0 with 0xFF → 0xFE, and no pulse ever occurs without a write.
